// File: rtl/csi_tx_packetizer_if.sv
// csi_tx_packetizer_if: groups the frame-request, payload and HS lane
// signals of the CSI-2 transmit packetizer. The packetizer connects through
// the slave modport. A frame source or bench connects through the master
// modport.
interface csi_tx_packetizer_if;
  logic        frame_start;
  logic [15:0] payload_dat;
  logic        payload_vld;
  logic        payload_rdy;
  logic [15:0] lane_dat;
  logic        lane_hs_en;
  logic        frame_busy;
  logic        frame_done;
  logic [15:0] frame_num;
  logic        err_underflow;

  modport master (
    output frame_start,
    output payload_dat,
    output payload_vld,
    input  payload_rdy,
    input  lane_dat,
    input  lane_hs_en,
    input  frame_busy,
    input  frame_done,
    input  frame_num,
    input  err_underflow
  );

  modport slave (
    input  frame_start,
    input  payload_dat,
    input  payload_vld,
    output payload_rdy,
    output lane_dat,
    output lane_hs_en,
    output frame_busy,
    output frame_done,
    output frame_num,
    output err_underflow
  );
endinterface

// File: rtl/csi_tx_packetizer.sv
// csi_tx_packetizer: byte-clock CSI-2 transmitter for a 2-lane link.
// Each frame is an FS short packet, then LINES long packets, then an FE
// short packet. Every packet starts with a sync word and a header with ECC.
// Long packets also carry a payload and a CRC-16. An LP gap follows every
// packet.
// The lane outputs are registered from the current FSM state, so lane_dat
// and lane_hs_en trail the state by one cycle. Payload words are taken in
// the same cycle that payload_rdy is high.
// Optional build macro CSI_TX_TEST_PATTERN_EN replaces the external payload
// with an internal ramp. In that build, byte n of line L is (n+L) mod 256.
module csi_tx_packetizer #(
  parameter int unsigned LINE_BYTES = 800,
  parameter int unsigned LINES      = 480,
  parameter logic [5:0]  DATA_TYPE  = 6'h2B,
  parameter logic [1:0]  VC         = 2'd0,
  parameter int unsigned LP_GAP     = 8
) (
  input logic               clk,
  input logic               reset,
  csi_tx_packetizer_if.slave bus
);

  localparam int unsigned BEATS  = LINE_BYTES / 2;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GAP_W  = (LP_GAP > 1) ? $clog2(LP_GAP) : 1;
  localparam int unsigned LINE_W = $clog2(LINES + 1);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LP_GAP - 1);
  localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(LINES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HDR0    = 3'd2,
    ST_HDR1    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CRC     = 3'd5,
    ST_GAP     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PKT_FS   = 2'd0,
    PKT_LONG = 2'd1,
    PKT_FE   = 2'd2
  } pkt_e;

  // CSI-2 header ECC over {WC_H, WC_L, DI}. The upper two ECC bits are zero.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CRC-16 (poly 0x8408). Processes one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // Processes a two-lane word. The lane0 byte goes first.
  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] w);
    return crc16_byte(crc16_byte(c, w[7:0]), w[15:8]);
  endfunction

  state_e            state_q, state_d;
  pkt_e              pkt_q, pkt_d;
  logic [7:0]        di_q, di_d;
  logic [15:0]       wc_q, wc_d;
  logic [15:0]       frame_num_q, frame_num_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       crc_q, crc_d;
  logic [15:0]       lane_dat_q, lane_dat_d;
  logic              lane_hs_en_q, lane_hs_en_d;
  logic              payload_rdy_q, payload_rdy_d;
  logic              frame_busy_q, frame_busy_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic              start_pkt_s;
  logic [15:0]       src_word_s;
  logic              src_vld_s;
  logic              rdy_en_s;
  logic [15:0]       tx_word_s;
  logic [5:0]        ecc_s;

`ifdef CSI_TX_TEST_PATTERN_EN
  logic [7:0] pat_q;

  assign src_word_s = {pat_q + 8'd1, pat_q};
  assign src_vld_s  = 1'b1;
  assign rdy_en_s   = 1'b0;

  // Ramp base: loads with the line index before the payload, then adds two bytes per beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= 8'd0;
    end else if (state_q == ST_HDR1) begin
      pat_q <= 8'(line_q);
    end else if (state_q == ST_PAYLOAD) begin
      pat_q <= pat_q + 8'd2;
    end else begin
      pat_q <= pat_q;
    end
  end
`else
  assign src_word_s = bus.payload_dat;
  assign src_vld_s  = bus.payload_vld;
  assign rdy_en_s   = 1'b1;
`endif

  // An underflowing beat is sent as zeros. The CRC also uses those zeros.
  assign tx_word_s = src_vld_s ? src_word_s : 16'h0000;
  assign ecc_s     = ecc6({wc_q, di_q});

  // Next-state logic: packet sequencing, counters, CRC and the registered lane outputs.
  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    di_d          = di_q;
    wc_d          = wc_q;
    frame_num_d   = frame_num_q;
    line_d        = line_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    crc_d         = crc_q;
    err_d         = err_q;
    start_pkt_s   = 1'b0;
    lane_dat_d    = 16'h0000;
    lane_hs_en_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          frame_num_d = (frame_num_q == 16'hFFFF) ? 16'h0001 : frame_num_q + 16'h0001;
          pkt_d       = PKT_FS;
          state_d     = ST_SYNC;
          start_pkt_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        state_d = ST_HDR0;
      end
      ST_HDR0: begin
        state_d = ST_HDR1;
      end
      ST_HDR1: begin
        crc_d  = 16'hFFFF;
        beat_d = '0;
        gap_d  = '0;
        if (pkt_q == PKT_LONG) begin
          state_d = ST_PAYLOAD;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_PAYLOAD: begin
        crc_d = crc16_word(crc_q, tx_word_s);
        if (!src_vld_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (beat_q == BEAT_LAST) begin
          state_d = ST_CRC;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_CRC: begin
        gap_d   = '0;
        line_d  = line_q + LINE_W'(1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + GAP_W'(1);
        end else begin
          case (pkt_q)
            PKT_FS: begin
              line_d      = '0;
              pkt_d       = PKT_LONG;
              state_d     = ST_SYNC;
              start_pkt_s = 1'b1;
            end
            PKT_LONG: begin
              if (line_q == LINE_END) begin
                pkt_d       = PKT_FE;
                state_d     = ST_SYNC;
                start_pkt_s = 1'b1;
              end else if (src_vld_s) begin
                pkt_d       = PKT_LONG;
                state_d     = ST_SYNC;
                start_pkt_s = 1'b1;
              end else begin
                state_d = ST_GAP;
              end
            end
            PKT_FE: begin
              state_d = ST_IDLE;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Latch the header of the packet about to start. The ECC reads these fields.
    if (start_pkt_s) begin
      case (pkt_d)
        PKT_FS: begin
          di_d = {VC, 6'h00};
          wc_d = frame_num_d;
        end
        PKT_FE: begin
          di_d = {VC, 6'h01};
          wc_d = frame_num_d;
        end
        default: begin
          di_d = {VC, DATA_TYPE};
          wc_d = 16'(LINE_BYTES);
        end
      endcase
    end else begin
      di_d = di_q;
      wc_d = wc_q;
    end

    // Lane bytes for the cycle the FSM is in now.
    case (state_q)
      ST_SYNC: begin
        lane_dat_d   = 16'hB8B8;
        lane_hs_en_d = 1'b1;
      end
      ST_HDR0: begin
        lane_dat_d   = {wc_q[7:0], di_q};
        lane_hs_en_d = 1'b1;
      end
      ST_HDR1: begin
        lane_dat_d   = {2'b00, ecc_s, wc_q[15:8]};
        lane_hs_en_d = 1'b1;
      end
      ST_PAYLOAD: begin
        lane_dat_d   = tx_word_s;
        lane_hs_en_d = 1'b1;
      end
      ST_CRC: begin
        lane_dat_d   = crc_q;
        lane_hs_en_d = 1'b1;
      end
      default: begin
        lane_dat_d   = 16'h0000;
        lane_hs_en_d = 1'b0;
      end
    endcase

    payload_rdy_d = (state_d == ST_PAYLOAD) && rdy_en_s;
    frame_busy_d  = (state_d != ST_IDLE);
    frame_done_d  = (state_q == ST_GAP) && (state_d == ST_IDLE);
  end

  // State, counters and output registers. Reset returns to IDLE and sends no FE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pkt_q         <= PKT_FS;
      di_q          <= 8'h00;
      wc_q          <= 16'h0000;
      frame_num_q   <= 16'h0000;
      line_q        <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      crc_q         <= 16'hFFFF;
      lane_dat_q    <= 16'h0000;
      lane_hs_en_q  <= 1'b0;
      payload_rdy_q <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_q         <= pkt_d;
      di_q          <= di_d;
      wc_q          <= wc_d;
      frame_num_q   <= frame_num_d;
      line_q        <= line_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      crc_q         <= crc_d;
      lane_dat_q    <= lane_dat_d;
      lane_hs_en_q  <= lane_hs_en_d;
      payload_rdy_q <= payload_rdy_d;
      frame_busy_q  <= frame_busy_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign bus.lane_dat      = lane_dat_q;
  assign bus.lane_hs_en    = lane_hs_en_q;
  assign bus.payload_rdy   = payload_rdy_q;
  assign bus.frame_busy    = frame_busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_num     = frame_num_q;
  assign bus.err_underflow = err_q;

endmodule

// File: doc/csi_tx_packetizer.md
Name: csi_tx_packetizer

Overview:
- Byte-clock CSI-2 packet transmitter for a 2-lane link. It is the sending end of the stream that the CSI receiver path decodes.
- Builds the frame sequence: Frame Start short packet, LINES long packets, Frame End short packet.
- Per-lane HS bytes carry sync, header with ECC, payload and CRC-16.
- Feeds a D-PHY serializer model or loopback bench in place of the camera, so the receive/ISP/HDMI chain can be exercised without a sensor.

Parameters:
- LINE_BYTES, 800, long-packet word count in bytes (640 px RAW10). Must be even and ≤ 65534.
- LINES, 480, long packets per frame.
- DATA_TYPE, 6'h2B, long-packet data type (RAW10).
- VC, 2'd0, virtual channel.
- LP_GAP, 8, idle cycles after every packet. Minimum 1.

Ports:
- clk  in  1  byte clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  request one frame; accepted only in IDLE
- payload_dat  in  16  [7:0] is byte 2k (lane0), [15:8] is byte 2k+1 (lane1)
- payload_vld  in  1  payload word available
- payload_rdy  out  1  high on every PAYLOAD cycle
- lane_dat  out  16  [7:0] lane0 byte, [15:8] lane1 byte
- lane_hs_en  out  1  HS burst active
- frame_busy  out  1  high from start acceptance until return to IDLE
- frame_done  out  1  one-cycle pulse on the GAP→IDLE transition after FE
- frame_num  out  16  frame counter carried in the FS/FE word count
- err_underflow  out  1  sticky payload underflow flag

Behaviour:
- Registered outputs; reset values:
  - lane_dat=0, lane_hs_en=0, payload_rdy=0, frame_busy=0, frame_done=0, err_underflow=0
  - frame_num=0, FSM=IDLE, line counter=0
- FSM states: IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC, GAP.
- IDLE: frame_start=1 → frame_num increments, wrapping 0xFFFF→1 (never 0). frame_busy=1, packet type=FS, go to SYNC. frame_start in any other state is ignored.
- SYNC: lane_dat=16'hB8B8, lane_hs_en=1.
- HDR0: lane0=DI={VC,DT}, lane1=WC[7:0].
- HDR1: lane0=WC[15:8], lane1=ECC.
- Packet fields:
  - FS: DT=0x00, WC=frame_num.
  - FE: DT=0x01, WC=frame_num.
  - Long: DT=DATA_TYPE, WC=LINE_BYTES.
- ECC: CSI-2 6-bit Hamming over D[23:0]={WC_H,WC_L,DI}, bits 7:6=0. Combinational from latched header fields.
- Short packet: HDR1 → GAP.
- Long packet: HDR1 → PAYLOAD for exactly LINE_BYTES/2 cycles, then CRC.
  - payload_rdy=1 in every PAYLOAD cycle, and only there.
  - vld=1: lane_dat=payload_dat.
  - vld=0: lane_dat=16'h0000 and err_underflow set (stays set until reset). The HS burst never stalls.
  - CRC covers the bytes actually transmitted, including substituted zeros.
- CRC state: CRC-16 poly x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, LSB-first, no final XOR.
  - Reinitialised in HDR1.
  - Updated by two bytes per cycle, lane0 byte first.
- CRC: lane0=CRC[7:0], lane1=CRC[15:8], then GAP.
- GAP: lane_hs_en=0, lane_dat=0 for LP_GAP cycles. Exit depends on what was just sent:
  - After FS: go to SYNC with type=long, line counter=0.
  - After a long packet: line counter +1. If it is below LINES, wait for payload_vld=1 (stay in GAP beyond LP_GAP if needed), then go to SYNC, long. At LINES, go to SYNC with type=FE.
  - After FE: go to IDLE, frame_done pulse, frame_busy=0.
- Cycle counts:
  - Short packet: 3 HS cycles.
  - Long packet: LINE_BYTES/2+4 HS cycles.
  - Frame length (frame_start accepted → frame_done): 2·(3+LP_GAP) + LINES·(LINE_BYTES/2+4+LP_GAP) cycles, plus any payload wait.
- Reset mid-frame: next cycle in IDLE with all outputs at reset values. No FE is emitted.

Optional Feature:
- Macro: CSI_TX_TEST_PATTERN_EN.
- Defined:
  - Internal pattern replaces payload_dat. Byte n of line L = (n+L) mod 256.
  - payload_rdy is held 0; payload_vld is ignored, including the GAP wait.
  - err_underflow is never set.
- Undefined: external payload path exactly as above.

Test Plan:
- Reset, then frame_start with LINES=2, LINE_BYTES=4, LP_GAP=1.
  - First HS cycles: B8B8, then lane0=00/lane1=01, then lane0=00/lane1=1A (FS, frame 1, ECC 0x1A).
  - frame_done pulses 2·4+2·7=22 cycles after acceptance.
- Long packet with payload words 0x0201, 0x0403:
  - lane_dat sequence B8B8, 042B, ECC/00, 0201, 0403.
  - CRC word equals the bench reference CRC-16 over bytes 01 02 03 04.
- Drop payload_vld for one PAYLOAD cycle:
  - That cycle lane_dat=0000.
  - err_underflow=1 and stays 1 through later frames.
  - Packet length unchanged.
- frame_start pulsed while busy → ignored; exactly one FE. After 65535 frames (force frame_num=FFFF), the next FS carries WC=0001.
- Assert reset during PAYLOAD → next cycle lane_hs_en=0, frame_busy=0. A new frame_start yields an FS with frame_num=1.
- With CSI_TX_TEST_PATTERN_EN, line 1 payload = 01 02 03 04, payload_rdy constantly 0.
